// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM states, PC step and the buffered entry format.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Small {pc, instr} buffer between fetch and decode; flush wins over push.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, single-outstanding request FSM, response buffer
// and pre-sliced I/S/U immediates for decode.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [11:0] id_iimm,
  output logic [11:0] id_simm,
  output logic [19:0] id_uimm
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_nx;
  logic [31:0]   pc;
  logic [31:0]   pc_nx;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          push;
  logic          pop;
  logic          flush;
  logic          issue;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign id_valid    = (count != '0);
  assign flush       = redirect_valid;
  assign pop         = id_valid && id_ready && !redirect_valid;
  assign push        = (state == FETCH_WAIT) && imem_rvalid && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);

  // Issuing only while a slot is left after this cycle's push/pop guarantees
  // the next response always has room, so nothing is ever lost to overflow.
  assign issue = !rst && !redirect_valid &&
                 ((state == FETCH_IDLE) || ((state == FETCH_WAIT) && imem_rvalid)) &&
                 (count_after < CW'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign push_data = '{pc: req_pc, instr: imem_rdata};

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if (redirect_valid) begin
      pc_nx = align_word(redirect_pc);
      case (state)
        FETCH_WAIT, FETCH_DROP: state_nx = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
        default:                state_nx = FETCH_IDLE;
      endcase
    end else begin
      if (issue) begin
        pc_nx = pc + PC_STEP;
      end
      case (state)
        FETCH_IDLE: if (issue) state_nx = FETCH_WAIT;
        FETCH_WAIT: if (imem_rvalid) state_nx = issue ? FETCH_WAIT : FETCH_IDLE;
        FETCH_DROP: if (imem_rvalid) state_nx = FETCH_IDLE;
        default:    state_nx = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH_IDLE;
      pc     <= align_word(RESET_PC);
      req_pc <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (issue) begin
        req_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  assign id_pc    = head.pc;
  assign id_instr = head.instr;
  assign id_iimm  = id_instr[31:20];
  assign id_simm  = {id_instr[31:25], id_instr[11:7]};
  assign id_uimm  = id_instr[31:12];

endmodule
